// File: rtl/bin_acc_pkg.sv
// Shared types and helpers for the bin accumulator: dump FSM states, width
// helpers and a saturating adder that clamps to a run-time signed width.
package bin_acc_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {IDLE, STREAM} dump_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Operands arrive sign-extended to MAX_W; the result is clamped to w bits.
  function automatic logic signed [MAX_W-1:0] sat_add(
    input  logic signed [MAX_W-1:0] a,
    input  logic signed [MAX_W-1:0] b,
    input  int                      w,
    output logic                    sat
  );
    logic signed [MAX_W:0] s, one, hi, lo;
    one = {{MAX_W{1'b0}}, 1'b1};
    s   = {a[MAX_W-1], a} + {b[MAX_W-1], b};
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    sat = 1'b0;
    sat_add = s[MAX_W-1:0];
    if (s > hi) begin
      sat = 1'b1;
      sat_add = hi[MAX_W-1:0];
    end else if (s < lo) begin
      sat = 1'b1;
      sat_add = lo[MAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/bin_acc_dump.sv
// Shadow buffer and valid/ready readout: snapshots all sums when an
// integration completes while idle, then streams them out one bin per beat.
module bin_acc_dump
  import bin_acc_pkg::*;
#(
  parameter int BINS            = 4,
  parameter int SUM_W           = 48,
  parameter int LOG2_FRAMES_MAX = 8,
  localparam int BIN_W = cnt_w(BINS),
  localparam int K_W   = cnt_w(LOG2_FRAMES_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done,
  input  logic [BINS-1:0][SUM_W-1:0] acc,
  input  logic [K_W-1:0]             k,
  input  logic                       avg,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [SUM_W-1:0]           out_data,
  output logic [BIN_W-1:0]           out_bin,
  output logic                       out_last,
  output logic                       drop
);

  dump_state_t              state, state_nxt;
  logic [BINS-1:0][SUM_W-1:0] shadow;
  logic [K_W-1:0]           k_s;
  logic                     avg_s;
  logic                     snap, drop_nxt, bin_last;
  logic signed [SUM_W-1:0]  cur;

  assign bin_last = (out_bin == BIN_W'(BINS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Completion is only taken from IDLE; the final-handshake cycle is still
  // STREAM, so a completion landing there is dropped too.
  always_comb begin
    state_nxt = state;
    snap      = 1'b0;
    drop_nxt  = 1'b0;
    case (state)
      IDLE: if (done) begin
        snap      = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        drop_nxt = done;
        if (out_ready && bin_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      k_s     <= '0;
      avg_s   <= 1'b0;
      out_bin <= '0;
      drop    <= 1'b0;
    end else begin
      drop <= drop_nxt;
      if (snap) begin
        shadow  <= acc;
        k_s     <= k;
        avg_s   <= avg;
        out_bin <= '0;
      end else if (state == STREAM && out_ready) begin
        out_bin <= bin_last ? '0 : out_bin + BIN_W'(1);
      end
    end
  end

  assign out_valid = (state == STREAM);
  assign out_last  = out_valid && bin_last;
  assign cur       = $signed(shadow[out_bin]);
  assign out_data  = avg_s ? (cur >>> k_s) : cur;

endmodule

// File: rtl/bin_accumulator_avg.sv
// Integrates BINS-bin frames over 2^k frames with saturation and framing
// checks, handing completed sums to the dump stage for readout.
module bin_accumulator_avg
  import bin_acc_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int BINS            = 4,
  parameter int SUM_W           = 48,
  parameter int LOG2_FRAMES_MAX = 8,
  localparam int BIN_W = cnt_w(BINS),
  localparam int K_W   = cnt_w(LOG2_FRAMES_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [K_W-1:0]    cfg_log2_frames,
  input  logic              cfg_avg,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_data,
  output logic [BIN_W-1:0]  out_bin,
  output logic              out_last,
  output logic              overflow,
  output logic              frame_err,
  output logic              drop
);

  localparam int F_W = LOG2_FRAMES_MAX + 1;

  if (SUM_W < DATA_W + 1) begin : g_sum_w_chk
    $error("SUM_W must be at least DATA_W+1");
  end
  if (SUM_W > MAX_W || BINS < 2) begin : g_range_chk
    $error("SUM_W above MAX_W or BINS below 2");
  end

  logic [BINS-1:0][SUM_W-1:0] acc;
  logic [BIN_W-1:0]           bcnt;
  logic [F_W-1:0]             fcnt, frame_tgt;
  logic [K_W-1:0]             k_q, k_in, k_cur;
  logic                       avg_q, done, rst;
  logic                       first, start, last_bin, err, sat;
  logic signed [MAX_W-1:0]    sum;
  logic [SUM_W-1:0]           next_val;

  assign rst      = reset | clear;
  assign last_bin = (bcnt == BIN_W'(BINS - 1));
  assign first    = (fcnt == '0);
  assign start    = first && (bcnt == '0);
  assign err      = (in_last != last_bin);
  assign k_in     = (cfg_log2_frames > K_W'(LOG2_FRAMES_MAX)) ? K_W'(LOG2_FRAMES_MAX)
                                                              : cfg_log2_frames;
  // The first beat already carries the new k so that k=0 completes in frame 0.
  assign k_cur     = start ? k_in : k_q;
  assign frame_tgt = F_W'(1) << k_cur;

  always_comb begin
    sum      = sat_add(MAX_W'($signed(acc[bcnt])), MAX_W'($signed(in_data)), SUM_W, sat);
    next_val = first ? SUM_W'($signed(in_data)) : sum[SUM_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      bcnt      <= '0;
      fcnt      <= '0;
      k_q       <= '0;
      avg_q     <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      if (in_valid) begin
        if (err) begin
          frame_err <= 1'b1;
          bcnt      <= '0;
          fcnt      <= '0;
        end else begin
          acc[bcnt] <= next_val;
          if (!first && sat) overflow <= 1'b1;
          if (start) begin
            k_q   <= k_in;
            avg_q <= cfg_avg;
          end
          if (last_bin) begin
            bcnt <= '0;
            if (fcnt + F_W'(1) == frame_tgt) begin
              fcnt <= '0;
              done <= 1'b1;
            end else begin
              fcnt <= fcnt + F_W'(1);
            end
          end else begin
            bcnt <= bcnt + BIN_W'(1);
          end
        end
      end
    end
  end

  bin_acc_dump #(
    .BINS(BINS), .SUM_W(SUM_W), .LOG2_FRAMES_MAX(LOG2_FRAMES_MAX)
  ) u_dump (
    .clk(clk), .rst(rst), .done(done), .acc(acc), .k(k_q), .avg(avg_q),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_bin(out_bin), .out_last(out_last), .drop(drop)
  );

endmodule

// File: tb/tb_bin_accumulator_avg.sv
// Directed bench for bin_accumulator_avg: a 48-bit instance plus a 20-bit
// instance sharing the same stimulus for the saturation scenario.
module tb_bin_accumulator_avg;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_last, cfg_avg, clear, out_ready;
  logic [15:0] in_data;
  logic [3:0]  cfg_log2_frames;

  logic        out_valid, out_last, overflow, frame_err, drop;
  logic [47:0] out_data;
  logic [1:0]  out_bin;
  logic        s_valid, s_last, s_overflow, s_frame_err, s_drop;
  logic [19:0] s_data;
  logic [1:0]  s_bin;

  int errors = 0;
  int checks = 0;
  logic signed [47:0] exp48;

  always #5 clk = ~clk;

  bin_accumulator_avg #(.DATA_W(16), .BINS(4), .SUM_W(48), .LOG2_FRAMES_MAX(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .cfg_log2_frames(cfg_log2_frames), .cfg_avg(cfg_avg), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bin(out_bin),
    .out_last(out_last), .overflow(overflow), .frame_err(frame_err), .drop(drop)
  );

  bin_accumulator_avg #(.DATA_W(16), .BINS(4), .SUM_W(20), .LOG2_FRAMES_MAX(8)) dut20 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .cfg_log2_frames(cfg_log2_frames), .cfg_avg(cfg_avg), .clear(clear),
    .out_valid(s_valid), .out_ready(out_ready), .out_data(s_data), .out_bin(s_bin),
    .out_last(s_last), .overflow(s_overflow), .frame_err(s_frame_err), .drop(s_drop)
  );

  task automatic send(input int d, input bit last);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(d);
    in_last  = last;
  endtask

  // Frame f, bin b carries 100b+f over four frames; sums are 400b+6.
  task automatic send_std();
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 4; b++) send(100 * b + f, b == 3);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cfg_log2_frames = 4'd2; cfg_avg = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_last, overflow, frame_err, drop} !== 5'b0 || out_data !== 48'd0 || out_bin !== 2'd0) begin
      errors++;
      $display("FAIL reset: valid=%b last=%b ovf=%b ferr=%b drop=%b data=%0d bin=%0d, required all 0",
               out_valid, out_last, overflow, frame_err, drop, out_data, out_bin);
    end
    reset = 1'b0;
  endtask

  task automatic test_avg_stream();
    cfg_log2_frames = 4'd2; cfg_avg = 1'b1; out_ready = 1'b1;
    send_std();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL avg_latency_early: out_valid=%b required 0", out_valid);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_bin !== 2'(b) || out_data !== 48'(100 * b + 1) || out_last !== (b == 3)) begin
        errors++;
        $display("FAIL avg_stream bin%0d: valid=%b bin=%0d data=%0d last=%b, required 1/%0d/%0d/%b",
                 b, out_valid, out_bin, out_data, out_last, b, 100 * b + 1, b == 3);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL avg_stream_end: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_raw_backpressure();
    cfg_log2_frames = 4'd2; cfg_avg = 1'b0; out_ready = 1'b0;
    send_std();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_bin !== 2'd0 || out_data !== 48'd6) begin
        errors++;
        $display("FAIL raw_hold cyc%0d: valid=%b bin=%0d data=%0d, required 1/0/6", i, out_valid, out_bin, out_data);
      end
    end
    out_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_bin !== 2'(b) || out_data !== 48'(400 * b + 6)) begin
        errors++;
        $display("FAIL raw_stream bin%0d: valid=%b bin=%0d data=%0d, required 1/%0d/%0d",
                 b, out_valid, out_bin, out_data, b, 400 * b + 6);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL raw_stream_end: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    cfg_log2_frames = 4'd0; cfg_avg = 1'b0; out_ready = 1'b0;
    for (int b = 0; b < 4; b++) send(10 * (b + 1), b == 3);
    for (int b = 0; b < 4; b++) send(b + 1, b == 3);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (drop !== 1'b0) begin
      errors++; $display("FAIL drop_early: drop=%b required 0", drop);
    end
    @(negedge clk);
    checks++;
    if (drop !== 1'b1) begin
      errors++; $display("FAIL drop_pulse: drop=%b required 1", drop);
    end
    @(negedge clk);
    checks++;
    if (drop !== 1'b0 || out_valid !== 1'b1 || out_data !== 48'd10 || out_bin !== 2'd0) begin
      errors++;
      $display("FAIL drop_after: drop=%b valid=%b data=%0d bin=%0d, required 0/1/10/0", drop, out_valid, out_data, out_bin);
    end
    out_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 48'(10 * (b + 1)) || out_bin !== 2'(b)) begin
        errors++;
        $display("FAIL b2b_stream bin%0d: valid=%b data=%0d bin=%0d, required 1/%0d/%0d",
                 b, out_valid, out_data, out_bin, 10 * (b + 1), b);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    cfg_log2_frames = 4'd15; cfg_avg = 1'b0; out_ready = 1'b1;
    for (int f = 0; f < 256; f++)
      for (int b = 0; b < 4; b++) send(32767, b == 3);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (s_overflow !== 1'b1 || overflow !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_flag: ovf20=%b ovf48=%b valid20=%b, required 1/0/0", s_overflow, overflow, s_valid);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      checks++;
      if (s_valid !== 1'b1 || s_data !== 20'd524287 || s_bin !== 2'(b) || out_data !== 48'd8388352) begin
        errors++;
        $display("FAIL sat_stream bin%0d: valid20=%b data20=%0d bin20=%0d data48=%0d, required 1/524287/%0d/8388352",
                 b, s_valid, s_data, s_bin, b, out_data);
      end
    end
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b0 || s_overflow !== 1'b1) begin
      errors++; $display("FAIL sat_sticky: valid20=%b ovf20=%b, required 0/1", s_valid, s_overflow);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (s_overflow !== 1'b0) begin
      errors++; $display("FAIL sat_clear: ovf20=%b required 0", s_overflow);
    end
  endtask

  task automatic test_frame_err();
    cfg_log2_frames = 4'd2; cfg_avg = 1'b0; out_ready = 1'b1;
    for (int b = 0; b < 4; b++) send(5000, b == 3);
    send(5000, 1'b0);
    send(5000, 1'b0);
    send(5000, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL frame_err_pulse: frame_err=%b required 1", frame_err);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL frame_err_after: frame_err=%b valid=%b, required 0/0", frame_err, out_valid);
    end
    send_std();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_bin !== 2'(b) || out_data !== 48'(400 * b + 6)) begin
        errors++;
        $display("FAIL resync_stream bin%0d: valid=%b bin=%0d data=%0d, required 1/%0d/%0d",
                 b, out_valid, out_bin, out_data, b, 400 * b + 6);
      end
    end
  endtask

  task automatic test_neg_avg_reset();
    @(negedge clk);
    cfg_log2_frames = 4'd1; cfg_avg = 1'b1; out_ready = 1'b0;
    send(-3, 1'b0); send(5, 1'b0); send(0, 1'b0); send(0, 1'b1);
    send(-2, 1'b0); send(6, 1'b0); send(0, 1'b0); send(0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    exp48 = -48'sd3;
    checks++;
    if (out_valid !== 1'b1 || out_bin !== 2'd0 || out_data !== exp48) begin
      errors++;
      $display("FAIL neg_avg bin0: valid=%b bin=%0d data=%0d, required 1/0/-3", out_valid, out_bin, $signed(out_data));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_bin !== 2'd1 || out_data !== 48'd5) begin
      errors++;
      $display("FAIL neg_avg bin1: valid=%b bin=%0d data=%0d, required 1/1/5", out_valid, out_bin, out_data);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || out_bin !== 2'd0 || out_data !== 48'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b ovf=%b bin=%0d data=%0d last=%b, required all 0",
               out_valid, overflow, out_bin, out_data, out_last);
    end
  endtask

  initial begin
    test_reset();
    test_avg_stream();
    test_raw_backpressure();
    test_back_to_back();
    test_saturation();
    test_frame_err();
    test_neg_avg_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_accumulator_avg.md
Name: bin_accumulator_avg

Overview:
- Parametrised successor to the FFT bin collector.
- Accumulates a serial stream of BINS-bin frames (one bin per valid beat) over 2^k frames, where k is configurable.
- At the end of each integration, snapshots all sums into a shadow buffer and streams them out on a valid/ready interface, as raw sums or shift-averages.
- Sits between the FFT core output and the readout/DMA packetiser.

Parameters:
- DATA_W, 16: signed input sample width.
- BINS, 4: bins per frame; must be >= 2.
- SUM_W, 48: accumulator and output width; must be >= DATA_W+1 (elaboration assertion).
- LOG2_FRAMES_MAX, 8: largest allowed integration exponent k.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat qualifier; the source cannot stall, so there is no ready.
- in_data  in  DATA_W  signed bin sample.
- in_last  in  1  marks the final bin of a frame.
- cfg_log2_frames  in  $clog2(LOG2_FRAMES_MAX+1)  integration exponent k.
- cfg_avg  in  1  1 = output sum>>>k; 0 = output raw sum.
- clear  in  1  synchronous soft clear; identical effect to reset.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  SUM_W  signed sum or average.
- out_bin  out  $clog2(BINS)  bin index of the current out_data.
- out_last  out  1  high with bin BINS-1.
- overflow  out  1  sticky; set by any saturation.
- frame_err  out  1  one-cycle pulse on a framing error.
- drop  out  1  one-cycle pulse when a completed integration is discarded.

Behaviour:
- Reset/clear values:
  - All outputs 0.
  - Accumulators 0; bin counter 0; frame counter 0.
  - Dump FSM in IDLE; overflow cleared.
- Input path, per accepted beat at bin index b:
  - On the first frame of an integration: acc[b] <= sign-extended in_data (load).
  - Otherwise: acc[b] <= sat(acc[b]+in_data).
  - Bin counter increments, wrapping after BINS-1.
- Saturation:
  - Results clamp to SUM_W signed max/min.
  - The clamp sets overflow, which stays set until reset/clear.
- Config latching:
  - k = min(cfg_log2_frames, LOG2_FRAMES_MAX), latched on the first beat of frame 0.
  - cfg_avg is latched at the same point.
  - Mid-integration config changes are ignored.
- Frame end:
  - in_last on bin BINS-1 increments the frame counter.
  - When the frame counter reaches 2^k, the integration is complete and the frame counter returns to 0.
- Framing error: in_last on b != BINS-1, or b == BINS-1 without in_last, causes:
  - frame_err pulse at the next edge;
  - bin counter and frame counter reset to 0, so the next beat starts a fresh integration with a load.
  - The erroneous beat is not accumulated.
  - If in_last is absent, the counter still resynchronises at the next in_last.
- Snapshot:
  - On the edge after the completing beat, shadow <= acc (all bins in parallel), and the FSM goes IDLE -> STREAM.
  - out_valid is high from that edge on, i.e. 2 edges after the final beat edge.
  - A first beat of the next integration arriving on the snapshot edge loads acc in the same edge; the shadow captures the pre-load values.
- STREAM:
  - out_bin starts at 0; out_data = cfg_avg ? shadow[out_bin]>>>k : shadow[out_bin].
  - The arithmetic shift rounds toward -inf.
  - Each edge with out_valid & out_ready advances out_bin.
  - After the handshake on bin BINS-1 (out_last=1), the FSM goes STREAM -> IDLE and out_valid drops at that edge.
  - While out_ready=0, out_data, out_bin and out_last hold stable.
- Busy collision:
  - An integration completing while in STREAM is discarded: drop pulse, shadow untouched, stream continues.
  - The snapshot happens only from IDLE; this includes the cycle in which the last handshake occurs, where IDLE is not yet reached, so that completion is dropped.
- Reset/clear mid-operation: all outputs are 0 from the next edge, and any partial integration and pending dump are lost.

Decomposition:
- Package bin_acc_pkg:
  - sat_add function (SUM_W signed);
  - dump FSM state enum {IDLE, STREAM};
  - width localparam helpers.
- Sub-module bin_acc_dump: shadow registers, FSM, averaging shifter, valid/ready output.
- The top-level module holds the accumulators, counters and framing checks.

Test Plan (BINS=4, DATA_W=16, SUM_W=48 unless stated):
- k=2, cfg_avg=1, frame f bin b = 100b+f, out_ready=1 -> sums 400b+6; out_data = 100b+1 for b=0..3 on consecutive cycles; out_valid rises 2 edges after the final beat; out_last on bin 3.
- Same stimulus with cfg_avg=0 and out_ready low for 10 cycles after out_valid -> out_data=6 and out_bin=0 held for 10 cycles, then 6, 406, 806, 1206.
- k=0 back-to-back frames with out_ready=0 -> second completion pulses drop=1; the first snapshot is streamed intact when ready rises.
- SUM_W=20, k=8, in_data=32767 on every beat -> sums clamp at 524287; overflow=1 and stays 1 until clear.
- in_last on bin 2 during frame 1 -> frame_err pulse; the next 4 good frames (k=2) produce sums equal to those frames alone.
- k=1, cfg_avg=1, bin 0 inputs -3 and -2 -> out_data=-3 (-5>>>1); reset asserted while bin 1 is pending -> out_valid=0, overflow=0 at the next edge.
